// File: rtl/mcu_el2_lsu_dccm_stbuf.sv
// DCCM store buffer: in-order FIFO of committed word stores draining into the
// DCCM write port. Loads own the port unless the buffer is full or a flush is
// pending. Buffered stores are forwarded to matching loads (youngest wins).
module mcu_el2_lsu_dccm_stbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 39
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    input  logic                         ld_rden,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_stall,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    input  logic                         flush_req,
    output logic                         dccm_wren,
    output logic [ADDR_W-1:0]            dccm_wr_addr,
    output logic [DATA_W-1:0]            dccm_wr_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entries hold the word address only; byte offset bits are dropped.
    logic [ADDR_W-3:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              full;
    logic              drain_pri;
    logic              push;
    logic              pop;
    logic              match_any;
    logic [DATA_W-1:0] match_data;
    logic [PTR_W-1:0]  scan_idx;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // Status, handshake and drain arbitration against the load port.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        st_ready  = !full;
        push      = st_valid & st_ready;
        drain_pri = full | flush_req;
        dccm_wren = !empty & (!ld_rden | drain_pri);
        pop       = dccm_wren;
        ld_stall  = ld_rden & dccm_wren;
    end

    // Head entry feeds the DCCM write port; zeros when nothing is buffered.
    always_comb begin
        dccm_wr_addr = '0;
        dccm_wr_data = '0;
        if (!empty) begin
            dccm_wr_addr = {addr_mem[head], 2'b00};
            dccm_wr_data = data_mem[head];
        end
    end

    // Forwarding: scan oldest to youngest so the last match is the youngest.
    // Only registered entries are scanned, so a same-cycle enqueue is not seen.
    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (valid[scan_idx] && (addr_mem[scan_idx] == ld_addr[ADDR_W-1:2])) begin
                match_any  = 1'b1;
                match_data = data_mem[scan_idx];
            end
        end
        fwd_hit  = match_any & ld_rden;
        fwd_data = fwd_hit ? match_data : '0;
    end

    // Pointer, count and valid-bit state.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage, not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= st_addr[ADDR_W-1:2];
            data_mem[tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_mcu_el2_lsu_dccm_stbuf.sv
// Bench for the DCCM store buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_mcu_el2_lsu_dccm_stbuf;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 39;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_l;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              ld_rden;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_stall;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              flush_req;
    logic              dccm_wren;
    logic [ADDR_W-1:0] dccm_wr_addr;
    logic [DATA_W-1:0] dccm_wr_data;
    logic              empty;
    logic [CNT_W-1:0]  count;

    mcu_el2_lsu_dccm_stbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_l(rst_l),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_rden(ld_rden), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .flush_req(flush_req),
        .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending writes, oldest at index 0.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;
    ent_t mq[$];

    logic              m_full;
    logic              m_wren;
    logic              m_hit;
    logic [DATA_W-1:0] m_fd;
    ent_t              m_e;

    // Monitor: compare outputs mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        if (!rst_l) begin
            mq.delete();
            chk("rst_st_ready", st_ready, 1);
            chk("rst_empty", empty, 1);
            chk("rst_count", count, 0);
            chk("rst_wren", dccm_wren, 0);
            chk("rst_stall", ld_stall, 0);
            chk("rst_fwd_hit", fwd_hit, 0);
            chk("rst_wr_addr", dccm_wr_addr, 0);
        end else begin
            m_full = (mq.size() == DEPTH);
            m_wren = (mq.size() != 0) && (!ld_rden || m_full || flush_req);
            m_hit  = 1'b0;
            m_fd   = '0;
            if (ld_rden) begin
                foreach (mq[i]) begin
                    if (mq[i].a[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
                        m_hit = 1'b1;
                        m_fd  = mq[i].d;
                    end
                end
            end
            chk("st_ready", st_ready, !m_full);
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("wren", dccm_wren, m_wren);
            chk("ld_stall", ld_stall, ld_rden && m_wren);
            chk("fwd_hit", fwd_hit, m_hit);
            chk("fwd_data", fwd_data, m_fd);
            if (dccm_wren) begin
                if (mq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    chk("wr_addr", dccm_wr_addr, mq[0].a);
                    chk("wr_data", dccm_wr_data, mq[0].d);
                end
            end else if (mq.size() == 0) begin
                chk("idle_wr_addr", dccm_wr_addr, 0);
                chk("idle_wr_data", dccm_wr_data, 0);
            end
            if (m_wren && mq.size() != 0) void'(mq.pop_front());
            if (st_valid && !m_full) begin
                m_e.a = {st_addr[ADDR_W-1:2], 2'b00};
                m_e.d = st_data;
                mq.push_back(m_e);
            end
        end
    end

    task automatic set_in(input logic sv, input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                          input logic lr, input logic [ADDR_W-1:0] la, input logic fl);
        st_valid  = sv;
        st_addr   = sa;
        st_data   = sd;
        ld_rden   = lr;
        ld_addr   = la;
        flush_req = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] r;

    initial begin
        rst_l = 1'b0;
        set_in(0, '0, '0, 0, '0, 0);
        repeat (2) tick();
        rst_l = 1'b1;
        tick();

        // Single store on an idle port: written the next cycle, then empty.
        set_in(1, 16'h0104, 39'h12345678, 0, '0, 0);
        tick();
        set_in(0, '0, '0, 0, '0, 0);
        #1;
        chk("single_wren", dccm_wren, 1);
        chk("single_addr", dccm_wr_addr, 16'h0104);
        chk("single_data", dccm_wr_data, 39'h12345678);
        tick();
        chk("single_empty", empty, 1);

        // Fill while loads hold the port: drain only once full.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 16'h0400 + 16'(4*i), 39'(i + 1), 1, 16'h3000, 0);
            tick();
        end
        set_in(1, 16'h0500, 39'h55, 1, 16'h3000, 0);
        #1;
        chk("fill_count", count, 4);
        chk("fill_wren", dccm_wren, 1);
        chk("fill_stall", ld_stall, 1);
        chk("fill_st_ready", st_ready, 0);
        tick();
        set_in(0, '0, '0, 0, '0, 0);
        repeat (5) tick();

        // Youngest match is forwarded.
        set_in(1, 16'h0200, 39'hA, 1, 16'h3000, 0);
        tick();
        set_in(1, 16'h0200, 39'hB, 1, 16'h3000, 0);
        tick();
        set_in(0, '0, '0, 1, 16'h0202, 0);
        #1;
        chk("fwd_young_hit", fwd_hit, 1);
        chk("fwd_young_data", fwd_data, 39'hB);
        set_in(1, 16'h0300, 39'hC, 1, 16'h3000, 0);
        tick();

        // Flush with three entries: drain every cycle despite loads.
        set_in(0, '0, '0, 1, 16'h3000, 1);
        #1;
        chk("flush_wren", dccm_wren, 1);
        chk("flush_stall", ld_stall, 1);
        repeat (3) tick();
        chk("flush_empty", empty, 1);
        set_in(0, '0, '0, 0, '0, 0);
        tick();

        // Wrap-around: ten stores with interleaved drains.
        for (int i = 0; i < 10; i++) begin
            set_in(1, 16'h0800 + 16'(4*i), 39'(16'hA000 + i), (i % 3) != 0, 16'h3000, 0);
            tick();
        end
        set_in(0, '0, '0, 0, '0, 0);
        repeat (6) tick();

        // Reset while draining: outputs return to reset values at once.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 16'h0900 + 16'(4*i), 39'(16'hB000 + i), 1, 16'h3000, 0);
            tick();
        end
        set_in(0, '0, '0, 0, 16'h0900, 0);
        #2;
        rst_l = 1'b0;
        #1;
        chk("mid_rst_wren", dccm_wren, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ready", st_ready, 1);
        chk("mid_rst_data", dccm_wr_data, 0);
        repeat (2) tick();
        rst_l = 1'b1;
        repeat (4) tick();

        // Random traffic over a small address window to exercise matches.
        for (int c = 0; c < 1500; c++) begin
            r = {$urandom(), $urandom()};
            set_in($urandom_range(0, 9) < 6, 16'h0100 + 16'($urandom_range(0, 31)), r[DATA_W-1:0],
                   $urandom_range(0, 1) == 1, 16'h0100 + 16'($urandom_range(0, 31)),
                   $urandom_range(0, 9) == 0);
            tick();
        end
        set_in(0, '0, '0, 0, '0, 0);
        repeat (DEPTH + 2) tick();
        chk("final_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
